// File: rtl/m_rect_fill.sv
// Rectangle drawing engine: orders and optionally clips a corner pair, then raster-scans
// the box writing one RGB565 pixel per cycle. Clipping is enabled by `RECT_FILL_CLIP_EN.
module m_rect_fill #(
  parameter int SCR_W = 240,
  parameter int SCR_H = 240
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [7:0]  cmd_x1,
  input  logic [7:0]  cmd_y1,
  input  logic [15:0] cmd_color,
  input  logic        cmd_mode,
  output logic        wr_en,
  output logic [15:0] wr_adr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done
);

`ifdef RECT_FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [7:0] X_LIM = 8'(SCR_W - 1);
  localparam logic [7:0] Y_LIM = 8'(SCR_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRAW,
    S_DONE
  } state_t;

  state_t      state_q, state_nxt;

  logic [7:0]  x0_q, y0_q, x1_q, y1_q;
  logic [15:0] color_q;
  logic        mode_q;
  logic [7:0]  xl_q, xr_q, yt_q, yb_q;
  logic [7:0]  cx_q, cy_q;
  logic [15:0] last_adr_q, last_data_q;

  logic [7:0]  xl_s, xr_s, yt_s, yb_s;
  logic        empty_s;
  logic        at_xr, at_yb, edge_px;

  // Corner ordering and clipping, consumed only while in SETUP.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    xl_s    = (x0_q < x1_q) ? x0_q : x1_q;
    xr_s    = (x0_q < x1_q) ? x1_q : x0_q;
    yt_s    = (y0_q < y1_q) ? y0_q : y1_q;
    yb_s    = (y0_q < y1_q) ? y1_q : y0_q;
    empty_s = 1'b0;
    if (CLIP_EN) begin
      if (xr_s > X_LIM) xr_s = X_LIM;
      if (yb_s > Y_LIM) yb_s = Y_LIM;
      empty_s = (xl_s > X_LIM) || (yt_s > Y_LIM);
    end
  end

  // Compare before increment, so xr/yb = 255 terminates without wrapping.
  assign at_xr   = (cx_q == xr_q);
  assign at_yb   = (cy_q == yb_q);
  assign edge_px = (cx_q == xl_q) || at_xr || (cy_q == yt_q) || at_yb;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_SETUP) || (state_q == S_DRAW);
  assign done      = (state_q == S_DONE);
  assign wr_en     = (state_q == S_DRAW) && (!mode_q || edge_px);

  // Address/data hold the last written pixel whenever no write is strobed.
  assign wr_adr  = wr_en ? {cy_q, cx_q} : last_adr_q;
  assign wr_data = wr_en ? color_q : last_data_q;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid) state_nxt = S_SETUP;
      S_SETUP: state_nxt = empty_s ? S_DONE : S_DRAW;
      S_DRAW:  if (at_xr && at_yb) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      mode_q      <= 1'b0;
      xl_q        <= '0;
      xr_q        <= '0;
      yt_q        <= '0;
      yb_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      last_adr_q  <= '0;
      last_data_q <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        x0_q    <= cmd_x0;
        y0_q    <= cmd_y0;
        x1_q    <= cmd_x1;
        y1_q    <= cmd_y1;
        color_q <= cmd_color;
        mode_q  <= cmd_mode;
      end
      if (state_q == S_SETUP) begin
        xl_q <= xl_s;
        xr_q <= xr_s;
        yt_q <= yt_s;
        yb_q <= yb_s;
        cx_q <= xl_s;
        cy_q <= yt_s;
      end
      if (state_q == S_DRAW) begin
        if (at_xr) begin
          cx_q <= xl_q;
          cy_q <= cy_q + 8'd1;
        end else begin
          cx_q <= cx_q + 8'd1;
        end
      end
      if (wr_en) begin
        last_adr_q  <= {cy_q, cx_q};
        last_data_q <= color_q;
      end
    end
  end

endmodule

// File: tb/tb_m_rect_fill.sv
// Directed bench for m_rect_fill: fill, swapped corners, outline, edge-of-range,
// optional clipping, back-to-back handshake and reset abort.
module tb_m_rect_fill;

  logic        w_clk;
  logic        w_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [15:0] cmd_color;
  logic        cmd_mode;
  logic        wr_en;
  logic [15:0] wr_adr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [15:0] got_adr[$];
  int          data_bad;
  int          first_lat;
  int          done_lat;

  m_rect_fill dut (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .cmd_mode  (cmd_mode),
    .wr_en     (wr_en),
    .wr_adr    (wr_adr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) cyc <= cyc + 1;

  // Issues one command and records writes until done; latencies are 1-based cycles after the accept edge.
  task automatic send(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                      input logic [7:0] y1, input logic [15:0] col, input logic mode);
    int acc;
    int n;
    got_adr.delete();
    data_bad  = 0;
    first_lat = -1;
    done_lat  = -1;
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
    cmd_color = col; cmd_mode = mode; cmd_valid = 1'b1;
    @(negedge w_clk);
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge w_clk);
      n++;
    end
    acc = cyc + 1;
    @(posedge w_clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge w_clk);
      if (wr_en) begin
        got_adr.push_back(wr_adr);
        if (first_lat < 0) first_lat = cyc - acc + 1;
        if (wr_data !== col) data_bad++;
      end
      if (done) begin
        done_lat = cyc - acc + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready); else passed++;
    total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", wr_en); else passed++;
    total++; if (wr_adr !== 16'h0000) $display("FAIL reset_adr got=%h exp=0000", wr_adr); else passed++;
    total++; if (wr_data !== 16'h0000) $display("FAIL reset_data got=%h exp=0000", wr_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
  endtask

  task automatic check_fill_seq(input string tag);
    logic [15:0] exp_adr[6];
    exp_adr = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};
    total++; if (got_adr.size() != 6) $display("FAIL %s_count got=%0d exp=6", tag, got_adr.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= got_adr.size() || got_adr[i] !== exp_adr[i])
        $display("FAIL %s_adr%0d got=%h exp=%h", tag, i, (i < got_adr.size()) ? got_adr[i] : 16'hxxxx, exp_adr[i]);
      else passed++;
    end
    total++; if (data_bad != 0) $display("FAIL %s_data bad=%0d exp=0", tag, data_bad); else passed++;
    total++; if (first_lat != 2) $display("FAIL %s_first_lat got=%0d exp=2", tag, first_lat); else passed++;
    total++; if (done_lat != 8) $display("FAIL %s_done_lat got=%0d exp=8", tag, done_lat); else passed++;
  endtask

  task automatic test_fill;
    send(8'd10, 8'd20, 8'd12, 8'd21, 16'hF800, 1'b0);
    check_fill_seq("fill");
    @(negedge w_clk);
    total++; if (wr_adr !== 16'h150C) $display("FAIL fill_hold_adr got=%h exp=150C", wr_adr); else passed++;
    total++; if (wr_data !== 16'hF800) $display("FAIL fill_hold_data got=%h exp=F800", wr_data); else passed++;
  endtask

  task automatic test_swapped;
    send(8'd12, 8'd21, 8'd10, 8'd20, 16'hF800, 1'b0);
    check_fill_seq("swap");
  endtask

  task automatic test_outline;
    logic [15:0] exp_adr[$];
    int interior;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        if (x == 0 || x == 3 || y == 0 || y == 3) exp_adr.push_back({8'(y), 8'(x)});
    send(8'd0, 8'd0, 8'd3, 8'd3, 16'h001F, 1'b1);
    total++; if (got_adr.size() != 12) $display("FAIL outline_count got=%0d exp=12", got_adr.size()); else passed++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (i >= got_adr.size() || got_adr[i] !== exp_adr[i])
        $display("FAIL outline_adr%0d got=%h exp=%h", i, (i < got_adr.size()) ? got_adr[i] : 16'hxxxx, exp_adr[i]);
      else passed++;
    end
    interior = 0;
    foreach (got_adr[i])
      if (got_adr[i] inside {16'h0101, 16'h0102, 16'h0201, 16'h0202}) interior++;
    total++; if (interior != 0) $display("FAIL outline_interior got=%0d exp=0", interior); else passed++;
    total++; if (done_lat != 18) $display("FAIL outline_done_lat got=%0d exp=18", done_lat); else passed++;
  endtask

`ifdef RECT_FILL_CLIP_EN
  task automatic test_clip;
    logic [15:0] exp_adr[4];
    exp_adr = '{16'hEEEE, 16'hEEEF, 16'hEFEE, 16'hEFEF};
    send(8'd238, 8'd238, 8'd250, 8'd239, 16'h07E0, 1'b0);
    total++; if (got_adr.size() != 4) $display("FAIL clip_count got=%0d exp=4", got_adr.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_adr.size() || got_adr[i] !== exp_adr[i])
        $display("FAIL clip_adr%0d got=%h exp=%h", i, (i < got_adr.size()) ? got_adr[i] : 16'hxxxx, exp_adr[i]);
      else passed++;
    end
    total++; if (done_lat != 6) $display("FAIL clip_done_lat got=%0d exp=6", done_lat); else passed++;
    send(8'd245, 8'd0, 8'd250, 8'd5, 16'h07E0, 1'b0);
    total++; if (got_adr.size() != 0) $display("FAIL clip_empty_count got=%0d exp=0", got_adr.size()); else passed++;
    total++; if (done_lat != 2) $display("FAIL clip_empty_done_lat got=%0d exp=2", done_lat); else passed++;
  endtask
`else
  task automatic test_noclip_edge;
    send(8'd250, 8'd0, 8'd255, 8'd0, 16'h1234, 1'b0);
    total++; if (got_adr.size() != 6) $display("FAIL edge_count got=%0d exp=6", got_adr.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= got_adr.size() || got_adr[i] !== 16'(16'h00FA + i))
        $display("FAIL edge_adr%0d got=%h exp=%h", i, (i < got_adr.size()) ? got_adr[i] : 16'hxxxx, 16'(16'h00FA + i));
      else passed++;
    end
    total++; if (done_lat != 8) $display("FAIL edge_done_lat got=%0d exp=8", done_lat); else passed++;
    total++; if (data_bad != 0) $display("FAIL edge_data bad=%0d exp=0", data_bad); else passed++;
  endtask
`endif

  task automatic test_back_to_back;
    int ready_bad;
    int n;
    logic seen_done;
    cmd_x0 = 8'd10; cmd_y0 = 8'd20; cmd_x1 = 8'd12; cmd_y1 = 8'd21;
    cmd_color = 16'hF800; cmd_mode = 1'b0; cmd_valid = 1'b1;
    @(negedge w_clk);
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge w_clk);
      n++;
    end
    @(posedge w_clk);
    #1;
    cmd_x0 = 8'd5; cmd_y0 = 8'd5; cmd_x1 = 8'd5; cmd_y1 = 8'd5; cmd_color = 16'h07E0;
    ready_bad = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge w_clk);
      if (cmd_ready) ready_bad++;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    total++; if (!seen_done) $display("FAIL b2b_first_done got=0 exp=1"); else passed++;
    total++; if (ready_bad != 0) $display("FAIL b2b_ready_low got=%0d exp=0", ready_bad); else passed++;
    @(negedge w_clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_return got=%b exp=1", cmd_ready); else passed++;
    @(posedge w_clk);
    #1 cmd_valid = 1'b0;
    @(negedge w_clk);
    total++; if (busy !== 1'b1) $display("FAIL b2b_second_accept got=%b exp=1", busy); else passed++;
    @(negedge w_clk);
    total++;
    if (wr_en !== 1'b1 || wr_adr !== 16'h0505 || wr_data !== 16'h07E0)
      $display("FAIL b2b_second_write got=%b/%h/%h exp=1/0505/07E0", wr_en, wr_adr, wr_data);
    else passed++;
    @(negedge w_clk);
    total++; if (done !== 1'b1) $display("FAIL b2b_second_done got=%b exp=1", done); else passed++;
  endtask

  task automatic test_reset_abort;
    int stray;
    cmd_x0 = 8'd0; cmd_y0 = 8'd0; cmd_x1 = 8'd9; cmd_y1 = 8'd9;
    cmd_color = 16'hFFFF; cmd_mode = 1'b0; cmd_valid = 1'b1;
    @(negedge w_clk);
    for (int i = 0; i < 1000 && !cmd_ready; i++) @(negedge w_clk);
    @(posedge w_clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(negedge w_clk);
    total++; if (wr_en !== 1'b1) $display("FAIL abort_drawing got=%b exp=1", wr_en); else passed++;
    #2 w_rst_n = 1'b0;
    #1;
    total++; if (wr_en !== 1'b0) $display("FAIL abort_wr_en got=%b exp=0", wr_en); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready got=%b exp=1", cmd_ready); else passed++;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge w_clk);
      if (done || wr_en || busy) stray++;
    end
    total++; if (stray != 0) $display("FAIL abort_no_activity got=%0d exp=0", stray); else passed++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready_after got=%b exp=1", cmd_ready); else passed++;
  endtask

  initial begin
    w_rst_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    cmd_color = '0; cmd_mode = 1'b0;
    #1;
    test_reset;
    @(negedge w_clk);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    test_fill;
    test_swapped;
    test_outline;
`ifdef RECT_FILL_CLIP_EN
    test_clip;
`else
    test_noclip_edge;
`endif
    test_back_to_back;
    repeat (2) @(negedge w_clk);
    test_reset_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
